// File: rtl/delay_3_pipe_if.sv
// Data bus for delay_3_pipe. The optional valid pair is present only when
// DELAY_3_PIPE_VALID_EN is defined.
interface delay_3_pipe_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] _i_input;
  logic [WIDTH-1:0] __output;
`ifdef DELAY_3_PIPE_VALID_EN
  logic             _i_valid;
  logic             _o_valid;

  modport master (output _i_input, output _i_valid, input  __output, input  _o_valid);
  modport slave  (input  _i_input, input  _i_valid, output __output, output _o_valid);
`else
  modport master (output _i_input, input  __output);
  modport slave  (input  _i_input, output __output);
`endif
endinterface

// File: rtl/delay_3_pipe.sv
// Fixed-latency register pipeline: each word reappears DEPTH cycles later.
// Optional feature macro: DELAY_3_PIPE_VALID_EN (adds a parallel valid chain).
module delay_3_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic           _i_clk,
  input  logic           _i_rst_n,
  delay_3_pipe_if.slave  bus
);

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [WIDTH-1:0] w_stage0_d;

`ifdef DELAY_3_PIPE_VALID_EN
  logic [DEPTH-1:0] r_valid;

  // Invalid slots carry zero data so downstream never sees stale words.
  always_comb begin
    w_stage0_d = '0;
    if (bus._i_valid) w_stage0_d = bus._i_input;
  end

  always_ff @(posedge _i_clk or negedge _i_rst_n) begin
    if (!_i_rst_n) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= bus._i_valid;
      for (int k = 1; k < DEPTH; k++) r_valid[k] <= r_valid[k-1];
    end
  end

  assign bus._o_valid = r_valid[DEPTH-1];
`else
  always_comb begin
    w_stage0_d = bus._i_input;
  end
`endif

  always_ff @(posedge _i_clk or negedge _i_rst_n) begin
    if (!_i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else begin
      r_stage[0] <= w_stage0_d;
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  assign bus.__output = r_stage[DEPTH-1];

endmodule

// File: tb/tb_delay_3_pipe.sv
// Bench for delay_3_pipe: reset, pulse, stream table, random scoreboard,
// async reset mid-stream and a WIDTH=16/DEPTH=1 instance.
module tb_delay_3_pipe;
  localparam int W = 8;
  localparam int D = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  delay_3_pipe_if #(.WIDTH(W))  bus   ();
  delay_3_pipe_if #(.WIDTH(16)) bus16 ();

  delay_3_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    ._i_clk   (clk),
    ._i_rst_n (rst_n),
    .bus      (bus.slave)
  );

  delay_3_pipe #(.WIDTH(16), .DEPTH(1)) dut16 (
    ._i_clk   (clk),
    ._i_rst_n (rst_n),
    .bus      (bus16.slave)
  );

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] dout;
  } vec_t;

  vec_t         vecs [16];
  logic [W:0]   exp_q [$];
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d);
    bus._i_input = d;
`ifdef DELAY_3_PIPE_VALID_EN
    bus._i_valid = v;
`endif
  endtask

  // Compare at the current falling edge, drive the next word, advance one cycle.
  task automatic sb_step(input string name, input logic v, input logic [W-1:0] d);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_underflow"}, 16'd1, 16'd0);
    end else begin
      e = exp_q.pop_front();
      check(name, {8'h00, bus.__output}, {8'h00, e[W-1:0]});
`ifdef DELAY_3_PIPE_VALID_EN
      check({name, "_valid"}, {15'h0, bus._o_valid}, {15'h0, e[W]});
`endif
    end
    drive(v, d);
    exp_q.push_back({v, (v ? d : {W{1'b0}})});
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{8'h01, 8'h00}; vecs[1]  = '{8'h02, 8'h00};
    vecs[2]  = '{8'h03, 8'h00}; vecs[3]  = '{8'h04, 8'h01};
    vecs[4]  = '{8'h05, 8'h02}; vecs[5]  = '{8'h06, 8'h03};
    vecs[6]  = '{8'h07, 8'h04}; vecs[7]  = '{8'h08, 8'h05};
    vecs[8]  = '{8'h09, 8'h06}; vecs[9]  = '{8'h0A, 8'h07};
    vecs[10] = '{8'hFF, 8'h08}; vecs[11] = '{8'h00, 8'h09};
    vecs[12] = '{8'h80, 8'h0A}; vecs[13] = '{8'h00, 8'hFF};
    vecs[14] = '{8'h00, 8'h00}; vecs[15] = '{8'h00, 8'h80};

    // Reset held with all-ones input
    rst_n = 1'b0;
    drive(1'b1, 8'hFF);
    bus16._i_input = 16'hFFFF;
`ifdef DELAY_3_PIPE_VALID_EN
    bus16._i_valid = 1'b1;
`endif
    repeat (2) begin
      @(negedge clk);
      check("rst_hold", {8'h00, bus.__output}, 16'h0000);
      check("rst_hold16", bus16.__output, 16'h0000);
    end

    // Release away from the rising edge; stages hold zeros
    rst_n = 1'b1;
    drive(1'b1, 8'h00);
    bus16._i_input = 16'h0000;
    exp_q.delete();
    repeat (D) exp_q.push_back('0);
    repeat (3) sb_step("post_rst", 1'b1, 8'h00);

    // Single pulse
    sb_step("pulse_in", 1'b1, 8'h01);
    repeat (4) sb_step("pulse_out", 1'b1, 8'h00);

    // Stream and full-width patterns from the table
    for (int i = 0; i < 16; i++) begin
      check($sformatf("vec%0d", i), {8'h00, bus.__output}, {8'h00, vecs[i].dout});
      drive(1'b1, vecs[i].din);
      @(negedge clk);
    end
    exp_q.delete();
    repeat (D) exp_q.push_back({1'b1, {W{1'b0}}});

    // Random traffic
    for (int i = 0; i < 20; i++) begin
`ifdef DELAY_3_PIPE_VALID_EN
      sb_step("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
`else
      sb_step("rand", 1'b1, 8'($urandom_range(0, 255)));
`endif
    end

`ifdef DELAY_3_PIPE_VALID_EN
    sb_step("valid_a", 1'b1, 8'h33);
    sb_step("valid_b", 1'b0, 8'h44);
    repeat (D) sb_step("valid_tail", 1'b1, 8'h00);
`endif

    // Async reset mid-stream: in-flight A5/5A must vanish
    sb_step("pre_rst", 1'b1, 8'hA5);
    sb_step("pre_rst", 1'b1, 8'h5A);
    sb_step("pre_rst", 1'b1, 8'hA5);
    sb_step("pre_rst", 1'b1, 8'h5A);
    drive(1'b1, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {8'h00, bus.__output}, 16'h0000);
`ifdef DELAY_3_PIPE_VALID_EN
    check("async_rst_valid", {15'h0, bus._o_valid}, 16'h0000);
`endif
    #4 rst_n = 1'b1;
    @(negedge clk);
    repeat (6) begin
      check("no_inflight", {8'h00, bus.__output}, 16'h0000);
      @(negedge clk);
    end

    // WIDTH=16, DEPTH=1 instance
    bus16._i_input = 16'hBEEF;
    @(negedge clk);
    check("w16_d1", bus16.__output, 16'hBEEF);
    bus16._i_input = 16'h0000;
    @(negedge clk);
    check("w16_d1_next", bus16.__output, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
